// File: rtl/stack_unit_pkg.sv
// Shared types and default geometry for the stack engine and for decode,
// which uses the same bounds checker to predict faults early.
package stack_unit_pkg;

  typedef enum logic [1:0] {
    STACK_NOP  = 2'd0,
    STACK_PUSH = 2'd1,
    STACK_POP  = 2'd2,
    STACK_LOAD = 2'd3
  } stack_op_t;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_OVERFLOW   = 2'd1,
    FAULT_UNDERFLOW  = 2'd2,
    FAULT_LOAD_RANGE = 2'd3
  } stack_fault_t;

  typedef enum logic [1:0] {
    STACK_IDLE  = 2'd0,
    STACK_BURST = 2'd1,
    STACK_FAULT = 2'd2
  } stack_state_t;

  localparam int              STACK_SP_WIDTH_DEF = 16;
  localparam int              STACK_MAX_STEP_DEF = 4;
  localparam logic [15:0]     STACK_BASE_DEF     = 16'h1000;
  localparam logic [15:0]     STACK_LIMIT_DEF    = 16'h0F00;

endpackage

// File: rtl/stack_unit_bounds_check.sv
// Combinational legality check for one stack operation against the current SP.
// Comparisons are widened by one bit and never subtract, so nothing can wrap.
module stack_bounds_check
  import stack_unit_pkg::*;
#(
  parameter int                  SP_WIDTH    = STACK_SP_WIDTH_DEF,
  parameter int                  MAX_STEP    = STACK_MAX_STEP_DEF,
  parameter logic [SP_WIDTH-1:0] STACK_BASE  = STACK_BASE_DEF,
  parameter logic [SP_WIDTH-1:0] STACK_LIMIT = STACK_LIMIT_DEF,
  localparam int                 CW          = $clog2(MAX_STEP + 1)
) (
  input  logic [SP_WIDTH-1:0] sp,
  input  stack_op_t           op,
  input  logic [CW-1:0]       count,
  input  logic [SP_WIDTH-1:0] load_value,
  output logic                legal,
  output stack_fault_t        fault_code
);

  localparam int            XW      = SP_WIDTH + 1;
  localparam logic [XW-1:0] BASE_X  = {1'b0, STACK_BASE};
  localparam logic [XW-1:0] LIMIT_X = {1'b0, STACK_LIMIT};

  logic [CW-1:0] count_clamped_s;
  logic [XW-1:0] sp_x_s;
  logic [XW-1:0] n_x_s;
  logic [XW-1:0] lv_x_s;

  // Oversized word counts behave as MAX_STEP.
  always_comb begin
    if (count > CW'(MAX_STEP)) begin
      count_clamped_s = CW'(MAX_STEP);
    end else begin
      count_clamped_s = count;
    end
  end

  assign sp_x_s = {1'b0, sp};
  assign n_x_s  = XW'(count_clamped_s);
  assign lv_x_s = {1'b0, load_value};

  // Legality and fault classification per operation type.
  always_comb begin
    legal      = 1'b1;
    fault_code = FAULT_NONE;
    case (op)
      STACK_PUSH: begin
        // sp - n >= LIMIT, rewritten as sp >= LIMIT + n
        if (sp_x_s < (LIMIT_X + n_x_s)) begin
          legal      = 1'b0;
          fault_code = FAULT_OVERFLOW;
        end else begin
          legal      = 1'b1;
          fault_code = FAULT_NONE;
        end
      end
      STACK_POP: begin
        if ((sp_x_s + n_x_s) > BASE_X) begin
          legal      = 1'b0;
          fault_code = FAULT_UNDERFLOW;
        end else begin
          legal      = 1'b1;
          fault_code = FAULT_NONE;
        end
      end
      STACK_LOAD: begin
        if ((lv_x_s < LIMIT_X) || (lv_x_s > BASE_X)) begin
          legal      = 1'b0;
          fault_code = FAULT_LOAD_RANGE;
        end else begin
          legal      = 1'b1;
          fault_code = FAULT_NONE;
        end
      end
      STACK_NOP: begin
        legal      = 1'b1;
        fault_code = FAULT_NONE;
      end
      default: begin
        legal      = 1'b1;
        fault_code = FAULT_NONE;
      end
    endcase
  end

endmodule

// File: rtl/stack_unit.sv
// Stack engine: owns SP, runs N-word push/pop bursts one word per grant,
// handles SP load and latches bounds faults until explicitly cleared.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int                  SP_WIDTH    = STACK_SP_WIDTH_DEF,
  parameter int                  MAX_STEP    = STACK_MAX_STEP_DEF,
  parameter logic [SP_WIDTH-1:0] STACK_BASE  = STACK_BASE_DEF,
  parameter logic [SP_WIDTH-1:0] STACK_LIMIT = STACK_LIMIT_DEF,
  localparam int                 CW          = $clog2(MAX_STEP + 1)
) (
  input  logic                clk,
  input  logic                rst_async,
  input  logic                op_valid,
  output logic                op_ready,
  input  stack_op_t           op,
  input  logic [CW-1:0]       op_count,
  input  logic [SP_WIDTH-1:0] load_value,
  output logic [SP_WIDTH-1:0] sp,
  output logic                mem_req,
  output logic                mem_write,
  output logic [SP_WIDTH-1:0] mem_addr,
  input  logic                mem_gnt,
  output logic                done,
  output logic                fault,
  output stack_fault_t        fault_code,
  input  logic                fault_clear
);

  stack_state_t        state_r,      state_nxt_s;
  logic [SP_WIDTH-1:0] sp_r,         sp_nxt_s;
  logic [CW-1:0]       cnt_r,        cnt_nxt_s;
  logic                push_r,       push_nxt_s;
  logic                done_r,       done_nxt_s;
  logic                fault_r,      fault_nxt_s;
  stack_fault_t        code_r,       code_nxt_s;
  logic                mem_req_r,    mem_req_nxt_s;
  logic                mem_write_r,  mem_write_nxt_s;
  logic [SP_WIDTH-1:0] mem_addr_r,   mem_addr_nxt_s;

  logic [CW-1:0]       count_clamped_s;
  logic                legal_s;
  stack_fault_t        chk_code_s;

  stack_bounds_check #(
    .SP_WIDTH    (SP_WIDTH),
    .MAX_STEP    (MAX_STEP),
    .STACK_BASE  (STACK_BASE),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_bounds (
    .sp         (sp_r),
    .op         (op),
    .count      (op_count),
    .load_value (load_value),
    .legal      (legal_s),
    .fault_code (chk_code_s)
  );

  // Clamp the requested word count for the burst counter.
  always_comb begin
    if (op_count > CW'(MAX_STEP)) begin
      count_clamped_s = CW'(MAX_STEP);
    end else begin
      count_clamped_s = op_count;
    end
  end

  // Next-state, SP, counter, done and fault decisions.
  always_comb begin
    state_nxt_s = state_r;
    sp_nxt_s    = sp_r;
    cnt_nxt_s   = cnt_r;
    push_nxt_s  = push_r;
    done_nxt_s  = 1'b0;
    fault_nxt_s = fault_r;
    code_nxt_s  = code_r;
    case (state_r)
      STACK_IDLE: begin
        if (op_valid) begin
          if (!legal_s) begin
            state_nxt_s = STACK_FAULT;
            fault_nxt_s = 1'b1;
            code_nxt_s  = chk_code_s;
          end else if (op == STACK_LOAD) begin
            sp_nxt_s   = load_value;
            done_nxt_s = 1'b1;
          end else if (((op == STACK_PUSH) || (op == STACK_POP)) &&
                       (count_clamped_s != {CW{1'b0}})) begin
            state_nxt_s = STACK_BURST;
            cnt_nxt_s   = count_clamped_s;
            push_nxt_s  = (op == STACK_PUSH);
          end else begin
            // NOP or zero-length push/pop completes without memory traffic
            done_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = STACK_IDLE;
        end
      end
      STACK_BURST: begin
        if (mem_gnt) begin
          if (push_r) begin
            sp_nxt_s = sp_r - SP_WIDTH'(1);
          end else begin
            sp_nxt_s = sp_r + SP_WIDTH'(1);
          end
          cnt_nxt_s = cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_nxt_s = STACK_IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = STACK_BURST;
          end
        end else begin
          state_nxt_s = STACK_BURST;
        end
      end
      STACK_FAULT: begin
        if (fault_clear) begin
          state_nxt_s = STACK_IDLE;
          fault_nxt_s = 1'b0;
          code_nxt_s  = FAULT_NONE;
        end else begin
          state_nxt_s = STACK_FAULT;
        end
      end
      default: begin
        state_nxt_s = STACK_IDLE;
      end
    endcase
  end

  // Memory request for the upcoming cycle, derived from the next SP so outputs stay registered.
  always_comb begin
    mem_req_nxt_s   = (state_nxt_s == STACK_BURST);
    mem_write_nxt_s = mem_write_r;
    mem_addr_nxt_s  = mem_addr_r;
    if (state_nxt_s == STACK_BURST) begin
      mem_write_nxt_s = push_nxt_s;
      if (push_nxt_s) begin
        mem_addr_nxt_s = sp_nxt_s - SP_WIDTH'(1);
      end else begin
        mem_addr_nxt_s = sp_nxt_s;
      end
    end else begin
      mem_write_nxt_s = mem_write_r;
      mem_addr_nxt_s  = mem_addr_r;
    end
  end

  // State and output registers; reset aborts any burst immediately.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_r     <= STACK_IDLE;
      sp_r        <= STACK_BASE;
      cnt_r       <= {CW{1'b0}};
      push_r      <= 1'b0;
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
      code_r      <= FAULT_NONE;
      mem_req_r   <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= {SP_WIDTH{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      sp_r        <= sp_nxt_s;
      cnt_r       <= cnt_nxt_s;
      push_r      <= push_nxt_s;
      done_r      <= done_nxt_s;
      fault_r     <= fault_nxt_s;
      code_r      <= code_nxt_s;
      mem_req_r   <= mem_req_nxt_s;
      mem_write_r <= mem_write_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
    end
  end

  assign op_ready   = (state_r == STACK_IDLE);
  assign sp         = sp_r;
  assign mem_req    = mem_req_r;
  assign mem_write  = mem_write_r;
  assign mem_addr   = mem_addr_r;
  assign done       = done_r;
  assign fault      = fault_r;
  assign fault_code = code_r;

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a queue-based stack model.
module tb_stack_unit;
  import stack_unit_pkg::*;

  localparam int MAXS  = 4;
  localparam int BASE  = 32'h1000;
  localparam int LIMIT = 32'h0F00;

  logic         clk = 1'b0;
  logic         rst_async;
  logic         op_valid;
  logic         op_ready;
  stack_op_t    op;
  logic [2:0]   op_count;
  logic [15:0]  load_value;
  logic [15:0]  sp;
  logic         mem_req;
  logic         mem_write;
  logic [15:0]  mem_addr;
  logic         mem_gnt;
  logic         done;
  logic         fault;
  stack_fault_t fault_code;
  logic         fault_clear;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: idle / busy / faulted, SP, and the list of words still to move.
  int           m_mode;   // 0 idle, 1 busy, 2 faulted
  int           m_sp;
  int           m_q[$];
  bit           m_wr;
  bit           m_done;
  bit           m_fault;
  stack_fault_t m_code;

  stack_unit dut (
    .clk(clk), .rst_async(rst_async), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .op_count(op_count), .load_value(load_value), .sp(sp),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .done(done), .fault(fault), .fault_code(fault_code),
    .fault_clear(fault_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode  = 0;
    m_sp    = BASE;
    m_q.delete();
    m_wr    = 1'b0;
    m_done  = 1'b0;
    m_fault = 1'b0;
    m_code  = FAULT_NONE;
  endtask

  task automatic m_set_fault(input stack_fault_t c);
    m_mode  = 2;
    m_fault = 1'b1;
    m_code  = c;
  endtask

  // One clock edge of the stack's behaviour, given the inputs seen at that edge.
  task automatic m_step(input bit v, input stack_op_t o, input int c, input int lv,
                        input bit g, input bit clr);
    int n;
    int a;
    m_done = 1'b0;
    if (m_mode == 0 && v) begin
      n = (c > MAXS) ? MAXS : c;
      case (o)
        STACK_PUSH: begin
          if (m_sp - n < LIMIT) m_set_fault(FAULT_OVERFLOW);
          else if (n == 0) m_done = 1'b1;
          else begin
            for (int i = 1; i <= n; i++) m_q.push_back(m_sp - i);
            m_wr = 1'b1; m_mode = 1;
          end
        end
        STACK_POP: begin
          if (m_sp + n > BASE) m_set_fault(FAULT_UNDERFLOW);
          else if (n == 0) m_done = 1'b1;
          else begin
            for (int i = 0; i < n; i++) m_q.push_back(m_sp + i);
            m_wr = 1'b0; m_mode = 1;
          end
        end
        STACK_LOAD: begin
          if (lv < LIMIT || lv > BASE) m_set_fault(FAULT_LOAD_RANGE);
          else begin m_sp = lv; m_done = 1'b1; end
        end
        default: m_done = 1'b1;
      endcase
    end else if (m_mode == 1 && g) begin
      a = m_q.pop_front();
      m_sp = m_wr ? a : a + 1;
      if (m_q.size() == 0) begin m_mode = 0; m_done = 1'b1; end
    end else if (m_mode == 2 && clr) begin
      m_mode = 0; m_fault = 1'b0; m_code = FAULT_NONE;
    end
  endtask

  task automatic cycle(input bit v, input stack_op_t o, input int c, input int lv,
                       input bit g, input bit clr);
    op_valid = v; op = o; op_count = 3'(c); load_value = 16'(lv);
    mem_gnt = g; fault_clear = clr;
    @(posedge clk);
    m_step(v, o, c, lv, g, clr);
    #1;
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    chk("op_ready", op_ready, (m_mode == 0));
    chk("mem_req", mem_req, (m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("mem_addr", mem_addr, m_q[0]);
      chk("mem_write", mem_write, m_wr);
    end
    chk("sp", sp, m_sp);
    chk("done", done, m_done);
    chk("fault", fault, m_fault);
    chk("fault_code", fault_code, m_code);
  end

  initial begin
    m_reset();
    rst_async = 1'b1; op_valid = 1'b0; op = STACK_NOP; op_count = 3'd0;
    load_value = 16'h0000; mem_gnt = 1'b0; fault_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_async = 1'b0;
    chk("rst_sp", sp, 32'h1000);
    chk("rst_ready", op_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_fault", fault, 0);
    chk("rst_done", done, 0);

    // PUSH 3 with continuous grant
    cycle(1, STACK_PUSH, 3, 0, 1, 0);
    chk("push3_a0", mem_addr, 32'h0FFF);
    chk("push3_w", mem_write, 1);
    cycle(0, STACK_NOP, 0, 0, 1, 0);
    chk("push3_a1", mem_addr, 32'h0FFE);
    cycle(0, STACK_NOP, 0, 0, 1, 0);
    chk("push3_a2", mem_addr, 32'h0FFD);
    cycle(0, STACK_NOP, 0, 0, 1, 0);
    chk("push3_done", done, 1);
    chk("push3_sp", sp, 32'h0FFD);

    // POP 2, first cycle without grant
    cycle(1, STACK_POP, 2, 0, 0, 0);
    chk("pop2_a0", mem_addr, 32'h0FFD);
    chk("pop2_w", mem_write, 0);
    cycle(0, STACK_NOP, 0, 0, 0, 0);
    chk("pop2_hold", mem_addr, 32'h0FFD);
    cycle(0, STACK_NOP, 0, 0, 1, 0);
    chk("pop2_a1", mem_addr, 32'h0FFE);
    cycle(0, STACK_NOP, 0, 0, 1, 0);
    chk("pop2_done", done, 1);
    chk("pop2_sp", sp, 32'h0FFF);

    // POP 1 to reach the base, then an underflowing POP 1
    cycle(1, STACK_POP, 1, 0, 1, 0);
    cycle(0, STACK_NOP, 0, 0, 1, 0);
    chk("pop1_sp", sp, 32'h1000);
    cycle(1, STACK_POP, 1, 0, 1, 0);
    chk("unf_fault", fault, 1);
    chk("unf_code", fault_code, FAULT_UNDERFLOW);
    chk("unf_ready", op_ready, 0);
    chk("unf_req", mem_req, 0);
    cycle(1, STACK_PUSH, 1, 0, 1, 1);
    chk("clr_ready", op_ready, 1);
    chk("clr_fault", fault, 0);
    chk("clr_req", mem_req, 0);
    chk("clr_sp", sp, 32'h1000);

    // LOAD near the limit, overflowing PUSH 3, then a legal PUSH 2
    cycle(1, STACK_LOAD, 0, 32'h0F02, 0, 0);
    chk("load_sp", sp, 32'h0F02);
    cycle(1, STACK_PUSH, 3, 0, 0, 0);
    chk("ovf_code", fault_code, FAULT_OVERFLOW);
    chk("ovf_sp", sp, 32'h0F02);
    cycle(0, STACK_NOP, 0, 0, 0, 1);
    cycle(1, STACK_PUSH, 2, 0, 1, 0);
    chk("push2_a0", mem_addr, 32'h0F01);
    cycle(0, STACK_NOP, 0, 0, 1, 0);
    chk("push2_a1", mem_addr, 32'h0F00);
    cycle(0, STACK_NOP, 0, 0, 1, 0);
    chk("push2_sp", sp, 32'h0F00);

    // Out-of-range LOAD
    cycle(1, STACK_LOAD, 0, 32'h1001, 0, 0);
    chk("lr_code", fault_code, FAULT_LOAD_RANGE);
    chk("lr_sp", sp, 32'h0F00);
    cycle(0, STACK_NOP, 0, 0, 0, 1);

    // Async reset in the middle of PUSH 4 after two grants
    cycle(1, STACK_LOAD, 0, 32'h1000, 0, 0);
    cycle(1, STACK_PUSH, 4, 0, 1, 0);
    cycle(0, STACK_NOP, 0, 0, 1, 0);
    cycle(0, STACK_NOP, 0, 0, 1, 0);
    chk("mid_sp", sp, 32'h0FFE);
    #2;
    rst_async = 1'b1;
    m_reset();
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_sp", sp, 32'h1000);
    chk("arst_done", done, 0);
    @(posedge clk);
    #1 rst_async = 1'b0;
    cycle(0, STACK_NOP, 0, 0, 1, 0);
    chk("arst_nodone", done, 0);

    // Randomized operations, grants and clears
    for (int k = 0; k < 800; k++) begin
      cycle($urandom_range(0, 1), stack_op_t'($urandom_range(0, 3)),
            $urandom_range(0, 7), $urandom_range(LIMIT - 3, BASE + 3),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0));
    end
    cycle(0, STACK_NOP, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Parametrised stack engine for the vgacpu core. It replaces the fixed SP_INC_1/2 and SP_DEC_1/2 steps with N-word push/pop bursts, SP load, bounds checking and fault latching.
- Sits between decode/control and the AGU/memory port. It owns the SP register and sequences one memory word per grant during multi-word operations.

Parameters:
- SP_WIDTH, 16, width of SP and memory word address.
- MAX_STEP, 4, maximum words per push/pop operation (>=1).
- STACK_BASE, 16'h1000, empty-stack SP value and exclusive top; also the reset value of sp.
- STACK_LIMIT, 16'h0F00, lowest legal SP (full stack); must be < STACK_BASE.

Ports:
- clk  in  1  core clock
- rst_async  in  1  asynchronous active-high reset
- op_valid  in  1  operation request
- op_ready  out  1  unit can accept an operation this cycle
- op  in  stack_op_t  STACK_NOP / STACK_PUSH / STACK_POP / STACK_LOAD
- op_count  in  CW=$clog2(MAX_STEP+1)  words to push/pop
- load_value  in  SP_WIDTH  new SP for STACK_LOAD
- sp  out  SP_WIDTH  current stack pointer
- mem_req  out  1  word access requested
- mem_write  out  1  1=push (store), 0=pop (load); valid when mem_req
- mem_addr  out  SP_WIDTH  word address; valid when mem_req
- mem_gnt  in  1  current word accepted
- done  out  1  one-cycle pulse: operation completed
- fault  out  1  latched fault present
- fault_code  out  stack_fault_t  FAULT_NONE / OVERFLOW / UNDERFLOW / LOAD_RANGE
- fault_clear  in  1  clears latched fault

Behaviour:
- Reset values: sp=STACK_BASE, state IDLE, op_ready=1, mem_req=0, mem_write=0, mem_addr=0, done=0, fault=0, fault_code=FAULT_NONE. Reset is async and aborts any burst immediately.
- States: IDLE, BURST, FAULT.
- Accept rule: an operation is accepted on op_valid && op_ready. op_ready=1 only in IDLE.
- op_count > MAX_STEP is clamped to MAX_STEP.
- Bounds checks are done at acceptance using SP_WIDTH+1-bit arithmetic, so wrap-around never passes a check.
  - PUSH n is legal iff sp - n >= STACK_LIMIT; else FAULT_OVERFLOW.
  - POP n is legal iff sp + n <= STACK_BASE; else FAULT_UNDERFLOW.
  - LOAD v is legal iff STACK_LIMIT <= v <= STACK_BASE; else FAULT_LOAD_RANGE.
- On a fault: sp unchanged, no mem_req, fault=1 and fault_code set the next cycle, go to FAULT.
- NOP, or PUSH/POP with count 0: done pulses next cycle, stay in IDLE, no memory traffic.
- LOAD (legal): sp<=v next cycle, done pulses next cycle, stay in IDLE.
- PUSH/POP n>=1 (legal): enter BURST next cycle, with the remaining-word counter = n.
- BURST, PUSH direction (stack grows downward, pre-decrement):
  - mem_req=1, mem_write=1, mem_addr=sp-1.
  - On mem_gnt: sp<=sp-1, counter-1.
- BURST, POP direction (post-increment):
  - mem_req=1, mem_write=0, mem_addr=sp.
  - On mem_gnt: sp<=sp+1, counter-1.
- Without mem_gnt, mem_req, mem_write and mem_addr hold stable.
- With continuous grant, an n-word burst uses exactly n cycles.
- When the last word is granted: done pulses in the following cycle, return to IDLE, op_ready=1 that same cycle. Back-to-back ops have one IDLE cycle minimum between bursts.
- FAULT: op_ready=0, mem_req=0.
  - fault_clear returns to IDLE next cycle with fault=0 and code FAULT_NONE.
  - op_valid during FAULT is ignored, including in the fault_clear cycle.
- fault_clear in IDLE or BURST has no effect.
- sp is always within [STACK_LIMIT, STACK_BASE].

Decomposition:
- Add to cpu_common: stack_op_t {STACK_NOP, STACK_PUSH, STACK_POP, STACK_LOAD}, stack_fault_t {FAULT_NONE, FAULT_OVERFLOW, FAULT_UNDERFLOW, FAULT_LOAD_RANGE}, stack_state_t {STACK_IDLE, STACK_BURST, STACK_FAULT}.
- sp_operation_t is retired once decode migrates.
- One combinational sub-module, stack_bounds_check: inputs sp, op, count, load_value; outputs legal and fault code. It is shared with decode for early fault prediction.

Test Plan (defaults):
- Reset: release rst_async -> sp=0x1000, op_ready=1, mem_req=0, fault=0, done=0.
- PUSH 3, mem_gnt held 1 -> mem_addr 0x0FFF, 0x0FFE, 0x0FFD on 3 consecutive cycles with mem_write=1; done next cycle; sp=0x0FFD.
- POP 2 from 0x0FFD, mem_gnt low on the first cycle:
  - 0x0FFD held 2 cycles with mem_write=0, then 0x0FFE;
  - done pulses; sp=0x0FFF.
- POP 1 at sp=0x1000 -> fault=1, FAULT_UNDERFLOW, sp unchanged, mem_req never asserted, op_ready=0.
  - op_valid with fault_clear in the same cycle -> op ignored, IDLE next cycle.
- LOAD 0x0F02 then PUSH 3 -> FAULT_OVERFLOW, sp=0x0F02. After clear, PUSH 2 -> addresses 0x0F01, 0x0F00; sp=0x0F00.
- LOAD 0x1001 -> FAULT_LOAD_RANGE, sp unchanged.
- rst_async asserted mid PUSH 4 after 2 grants -> mem_req=0 immediately (asynchronously), sp=0x1000, no done pulse.
